// File: rtl/barrel_coord_requester.sv
// rtl/barrel_coord_requester.sv - barrel-correction source-coordinate requester with AXI-Stream pixel output
// Optional BARREL_CLAMP_EN: saturate Math_X to [0, width-1] instead of wrapping modulo 4096.
module barrel_coord_requester #(
    parameter int width       = 1080,
    parameter int height      = 960,
    parameter int mem_latency = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [9:0]  Row_Gain,
    output logic [11:0] Math_X,
    output logic [11:0] Math_Y,
    input  logic        Math_Ready,
    input  logic [15:0] Mem_Data,
    output logic        Mem_Ready,
    output logic [15:0] AXIS_Out_Data,
    output logic        AXIS_Out_Valid,
    output logic        AXIS_Out_Last,
    output logic        AXIS_Out_User,
    input  logic        AXIS_Out_Ready
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int          CENTER = width / 2;
    localparam logic [11:0] X_LAST = 12'(width - 1);
    localparam logic [11:0] Y_LAST = 12'(height - 1);

    state_t state_q, state_d;
    logic [11:0] out_x_q, out_x_d, out_y_q, out_y_d;
    logic [9:0]  gain_q, gain_d;
    logic [11:0] math_x_q, math_x_d, math_y_q, math_y_d;
    // Tag bits: {valid, last, user}
    logic [2:0]  tag_q, tag_d;
    logic [mem_latency-1:0][2:0] pipe_q, pipe_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d, last_q, last_d, user_q, user_d;
    logic        done_q, done_d;

    logic        advance, any_inflight, final_hs;
    logic [9:0]  gain_eff;
    logic signed [23:0] diff, prod, mapped;
    logic [11:0] x_calc;

    assign advance   = AXIS_Out_Ready | ~valid_q;
    assign Mem_Ready = advance;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign Math_X    = math_x_q;
    assign Math_Y    = math_y_q;
    assign AXIS_Out_Data  = data_q;
    assign AXIS_Out_Valid = valid_q;
    assign AXIS_Out_Last  = last_q;
    assign AXIS_Out_User  = user_q;

    // The first pixel of a row uses the live gain; it is latched for the rest of the row.
    always_comb begin
        gain_eff = (out_x_q == 12'd0) ? Row_Gain : gain_q;
        diff     = $signed({12'd0, out_x_q}) - $signed(24'(CENTER));
        prod     = diff * $signed({14'd0, gain_eff});
        mapped   = (prod >>> 8) + $signed(24'(CENTER));
    end

`ifdef BARREL_CLAMP_EN
    always_comb begin
        if (mapped < 0)
            x_calc = 12'd0;
        else if (mapped > $signed(24'(width - 1)))
            x_calc = X_LAST;
        else
            x_calc = mapped[11:0];
    end
`else
    logic unused_mapped_hi;
    assign unused_mapped_hi = ^mapped[23:12];
    assign x_calc = mapped[11:0];
`endif

    always_comb begin
        any_inflight = tag_q[2];
        for (int i = 0; i < mem_latency; i++)
            any_inflight = any_inflight | pipe_q[i][2];
    end

    assign final_hs = valid_q & AXIS_Out_Ready & last_q & ~user_q & ~any_inflight;

    always_comb begin
        state_d  = state_q;
        out_x_d  = out_x_q;
        out_y_d  = out_y_q;
        gain_d   = gain_q;
        math_x_d = math_x_q;
        math_y_d = math_y_q;
        tag_d    = tag_q;
        pipe_d   = pipe_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        user_d   = user_q;
        done_d   = 1'b0;

        // Tag pipeline and output register move together with the memory pipeline.
        if (advance) begin
            tag_d     = 3'b000;
            pipe_d[0] = tag_q;
            for (int i = 1; i < mem_latency; i++)
                pipe_d[i] = pipe_q[i-1];
            data_d  = Mem_Data;
            valid_d = pipe_q[mem_latency-1][2];
            last_d  = pipe_q[mem_latency-1][1];
            user_d  = pipe_q[mem_latency-1][0];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    out_x_d = 12'd0;
                    out_y_d = 12'd0;
                end
            end
            RUN: begin
                if (advance && Math_Ready) begin
                    tag_d    = {1'b1, out_x_q == X_LAST, (out_x_q == 12'd0) && (out_y_q == 12'd0)};
                    math_x_d = x_calc;
                    math_y_d = out_y_q;
                    gain_d   = gain_eff;
                    if (out_x_q == X_LAST) begin
                        out_x_d = 12'd0;
                        if (out_y_q == Y_LAST) begin
                            out_y_d = 12'd0;
                            state_d = DRAIN;
                        end else begin
                            out_y_d = out_y_q + 12'd1;
                        end
                    end else begin
                        out_x_d = out_x_q + 12'd1;
                    end
                end
            end
            DRAIN: begin
                if (final_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            out_x_q  <= 12'd0;
            out_y_q  <= 12'd0;
            gain_q   <= 10'd0;
            math_x_q <= 12'd0;
            math_y_q <= 12'd0;
            tag_q    <= 3'b000;
            pipe_q   <= '0;
            data_q   <= 16'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            user_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
            gain_q   <= gain_d;
            math_x_q <= math_x_d;
            math_y_q <= math_y_d;
            tag_q    <= tag_d;
            pipe_q   <= pipe_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            user_q   <= user_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_barrel_coord_requester.sv
// tb/tb_barrel_coord_requester.sv - scoreboard bench for barrel_coord_requester with a behavioural memory and raster model
module tb_barrel_coord_requester;
    localparam int W = 8;
    localparam int H = 4;
    localparam int L = 2;
    localparam int WW = 1080;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, busy, done, math_ready, mem_ready, ov, ol, ou, ordy;
    logic [9:0]  row_gain;
    logic [11:0] math_x, math_y;
    logic [15:0] mem_data, od;

    logic        w_reset, w_start, w_busy, w_done, w_mem_ready, w_ov, w_ol, w_ou;
    logic [9:0]  w_gain;
    logic [11:0] w_mx, w_my;
    logic [15:0] w_od;

    barrel_coord_requester #(.width(W), .height(H), .mem_latency(L)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .Row_Gain(row_gain), .Math_X(math_x), .Math_Y(math_y), .Math_Ready(math_ready),
        .Mem_Data(mem_data), .Mem_Ready(mem_ready),
        .AXIS_Out_Data(od), .AXIS_Out_Valid(ov), .AXIS_Out_Last(ol), .AXIS_Out_User(ou),
        .AXIS_Out_Ready(ordy)
    );

    barrel_coord_requester #(.width(WW), .height(960), .mem_latency(L)) dut_wide (
        .clk(clk), .reset(w_reset), .start(w_start), .busy(w_busy), .done(w_done),
        .Row_Gain(w_gain), .Math_X(w_mx), .Math_Y(w_my), .Math_Ready(1'b1),
        .Mem_Data(16'd0), .Mem_Ready(w_mem_ready),
        .AXIS_Out_Data(w_od), .AXIS_Out_Valid(w_ov), .AXIS_Out_Last(w_ol), .AXIS_Out_User(w_ou),
        .AXIS_Out_Ready(1'b1)
    );

    // Memory: returns {row[3:0], column} of the coordinates presented L enabled edges earlier.
    logic [15:0] mpipe [L];
    always @(posedge clk) begin
        if (mem_ready) begin
            mpipe[0] <= {math_y[3:0], math_x};
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mem_data = mpipe[L-1];

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        u;
        logic        f;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    frame_gain [H];
    logic  exp_done = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int mx(input int x, input int g, input int wd);
        int c, p, q, v;
        c = wd / 2;
        p = (x - c) * g;
        if (p >= 0) q = p / 256;
        else q = -((-p + 255) / 256);
        v = c + q;
`ifdef BARREL_CLAMP_EN
        if (v < 0) v = 0;
        if (v > wd - 1) v = wd - 1;
`else
        v = ((v % 4096) + 4096) % 4096;
`endif
        return v;
    endfunction

    task automatic push_frame();
        beat_t b;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                b.d = 16'((y % 16) * 4096 + mx(x, frame_gain[y], W));
                b.l = (x == W - 1);
                b.u = (x == 0) && (y == 0);
                b.f = (x == W - 1) && (y == H - 1);
                sb.push_back(b);
            end
    endtask

    // Monitor: compares every accepted beat against the scoreboard and checks stall stability.
    logic        stall_prev = 1'b0;
    logic [15:0] s_d;
    logic        s_l, s_u;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (exp_done) begin
                chk("done_pulse", done, 1);
                exp_done = 1'b0;
            end else if (done) begin
                errors++;
                $display("FAIL done_spurious actual 1 required 0");
            end
            if (stall_prev) begin
                chk("stall_valid", ov, 1);
                chk("stall_data", od, s_d);
                chk("stall_last", ol, s_l);
                chk("stall_user", ou, s_u);
            end
            if (ov && !ordy) begin
                chk("mem_ready_stall", mem_ready, 0);
                stall_prev = 1'b1;
                s_d = od; s_l = ol; s_u = ou;
            end else begin
                stall_prev = 1'b0;
            end
            if (ov && ordy) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual data %0d required none", od);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    chk("beat_data", od, b.d);
                    chk("beat_last", ol, b.l);
                    chk("beat_user", ou, b.u);
                    if (b.f) exp_done = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode 0 clean, 1 per-row gain, 2 random stalls, 3 ready low 5 cycles,
    // 4 Math_Ready low 3 cycles, 5 reset at beat 10
    task automatic run_frame(input int mode, output int first_k, output int done_k, output int gaps);
        int hx, hy;
        hx = 0; hy = 0;
        first_k = -1; done_k = -1; gaps = 0;
        push_frame();
        math_ready = 1'b1; ordy = 1'b1;
        row_gain = 10'(frame_gain[0]);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int k = 0; k < 400 && done_k < 0; k++) begin
            math_ready = 1'b1; ordy = 1'b1;
            if (mode == 1) row_gain = (k % W == 0 && k < W * H) ? 10'(frame_gain[k / W]) : 10'($urandom_range(0, 1023));
            if (mode == 2) begin
                math_ready = ($urandom % 4) != 0;
                ordy = ($urandom % 3) != 0;
            end
            if (mode == 3 && k >= 10 && k < 15) ordy = 1'b0;
            if (mode == 4 && k >= 12 && k < 15) math_ready = 1'b0;
            if (mode == 4 && k == 12) begin hx = math_x; hy = math_y; end
            cyc();
            if (mode == 4 && k >= 12 && k < 15) begin
                chk("hold_math_x", math_x, hx);
                chk("hold_math_y", math_y, hy);
            end
            if (done) done_k = k;
            else if (ov && first_k < 0) first_k = k;
            else if (!ov && first_k >= 0) gaps++;
            if (mode == 5 && k == 13) begin
                reset = 1'b1;
                sb.delete();
                exp_done = 1'b0;
                cyc();
                chk("rst_mid_valid", ov, 0);
                chk("rst_mid_busy", busy, 0);
                reset = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    cyc();
                    chk("rst_idle_valid", ov, 0);
                end
                return;
            end
        end
        if (done_k < 0) begin
            errors++;
            $display("FAIL frame_timeout actual no done required done within 400 cycles");
        end
        chk("busy_after_done", busy, 0);
        cyc();
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic wide_check(input int g, input int req);
        w_reset = 1'b1;
        cyc();
        w_reset = 1'b0;
        w_gain = 10'(g);
        w_start = 1'b1;
        cyc();
        w_start = 1'b0;
        cyc();
        chk("wide_math_x_model", w_mx, mx(0, g, WW));
        chk("wide_math_x_const", w_mx, req);
        chk("wide_math_y", w_my, 0);
    endtask

    int fk, dk, gp;

    initial begin
        reset = 1'b1; start = 1'b0; math_ready = 1'b1; ordy = 1'b1; row_gain = 10'd256;
        w_reset = 1'b1; w_start = 1'b0; w_gain = 10'd256;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", ov, 0);
        chk("rst_last", ol, 0);
        chk("rst_user", ou, 0);
        chk("rst_data", od, 0);
        chk("rst_math_x", math_x, 0);
        chk("rst_math_y", math_y, 0);

        wide_check(128, 270);
`ifdef BARREL_CLAMP_EN
        wide_check(512, 0);
`else
        wide_check(512, 3556);
`endif
        w_reset = 1'b1;

        for (int r = 0; r < H; r++) frame_gain[r] = 256;
        run_frame(0, fk, dk, gp);
        chk("first_valid_latency", fk, L + 1);
        chk("done_latency", dk, W * H + L + 1);
        chk("unity_gaps", gp, 0);

        for (int r = 0; r < H; r++) frame_gain[r] = $urandom_range(0, 1023);
        run_frame(1, fk, dk, gp);
        chk("rowgain_gaps", gp, 0);

        for (int n = 0; n < 3; n++) begin
            frame_gain[0] = $urandom_range(0, 1023);
            for (int r = 1; r < H; r++) frame_gain[r] = frame_gain[0];
            run_frame(2, fk, dk, gp);
        end

        for (int r = 0; r < H; r++) frame_gain[r] = 300;
        run_frame(3, fk, dk, gp);

        for (int r = 0; r < H; r++) frame_gain[r] = 256;
        run_frame(4, fk, dk, gp);
        chk("math_ready_gap", gp, 3);

        run_frame(5, fk, dk, gp);

        for (int r = 0; r < H; r++) frame_gain[r] = 200;
        run_frame(0, fk, dk, gp);
        chk("restart_first_valid", fk, L + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/barrel_coord_requester.md
BARREL_COORD_REQUESTER -- requirements
Module: barrel_coord_requester

Interface
REQ-001 Parameter width, default 1080: output frame pixels per row.
REQ-002 Parameter height, default 960: output frame rows.
REQ-003 Parameter mem_latency, default 2: enabled clock edges from coordinate presentation to matching Mem_Data.
REQ-004 Port clk, input, 1: single clock; all logic posedge clk.
REQ-005 Port reset, input, 1: synchronous, active-high.
REQ-006 Port start, input, 1: single-cycle pulse that begins one frame.
REQ-007 Port busy, output, 1: high from the start edge until done.
REQ-008 Port done, output, 1: one-cycle pulse when the last pixel is accepted downstream.
REQ-009 Port Row_Gain, input, 10: unsigned 2.8 horizontal gain; 256 means 1.0.
REQ-010 Port Math_X, output, 12: source column request to the memory interface.
REQ-011 Port Math_Y, output, 12: source row request to the memory interface.
REQ-012 Port Math_Ready, input, 1: memory buffer holds enough rows to serve requests.
REQ-013 Port Mem_Data, input, 16: pixel returned by the memory interface.
REQ-014 Port Mem_Ready, output, 1: pipeline enable to the memory interface (its AXIS_Out_Ready).
REQ-015 Ports AXIS_Out_Data (16), AXIS_Out_Valid (1), AXIS_Out_Last (1) and AXIS_Out_User (1) are outputs; AXIS_Out_Ready (1) is an input. Together they form the downstream AXI-Stream.

Function
REQ-016 States: IDLE, RUN, DRAIN. start in IDLE moves to RUN. start is ignored outside IDLE.
REQ-017 advance = AXIS_Out_Ready OR NOT AXIS_Out_Valid. Mem_Ready = advance, combinationally.
REQ-018 In RUN, a request issues on a clk edge with advance AND Math_Ready high. Math_X and Math_Y are registered with a valid tag set.
REQ-019 In RUN with advance high and Math_Ready low, a bubble (tag valid = 0) enters the pipeline and the coordinates hold.
REQ-020 Output counters out_x and out_y advance raster order per issued request. out_x wraps at width-1, and out_y then increments.
REQ-021 Row_Gain is latched when a request with out_x = 0 issues. That latched value applies to the whole row.
REQ-022 Math_Y = out_y.
REQ-023 Math_X = center + ((out_x - center) * gain) arithmetic-shifted right by 8, where center = width/2. Use 13-bit signed difference and 24-bit signed product.
REQ-024 Tags {valid, last = (out_x == width-1), user = (out_x == 0 AND out_y == 0)} travel through a mem_latency-deep shift register. The shift register moves only on advance.
REQ-025 On advance, the output register loads Mem_Data and the tag from the final stage into AXIS_Out_Data, Valid, Last and User.
REQ-026 While AXIS_Out_Valid is high and AXIS_Out_Ready is low, all AXIS_Out signals hold stable.
REQ-027 Issuing the request for (width-1, height-1) moves the state to DRAIN. No further requests issue.
REQ-028 DRAIN moves to IDLE when the handshake with AXIS_Out_Last AND AXIS_Out_User=0 for the final pixel completes and no valid tags remain. done pulses in that cycle.
REQ-029 Throughput is 1 pixel/clk when Math_Ready and AXIS_Out_Ready are both continuously high. First AXIS_Out_Valid occurs mem_latency+1 cycles after the first request.

Reset
REQ-030 On reset: state IDLE, busy 0, done 0, counters 0, Math_X 0, Math_Y 0, all tags 0, AXIS_Out_Valid/Last/User 0, AXIS_Out_Data 0.
REQ-031 Reset mid-frame discards all in-flight tags. No AXIS_Out_Valid appears until a new start.

Configuration
REQ-032 With macro BARREL_CLAMP_EN defined, Math_X saturates to the range [0, width-1].
REQ-033 Without BARREL_CLAMP_EN, Math_X is the low 12 bits of the computed value (modulo 4096).

Verification
REQ-034 Use width=8 and height=4. Set Row_Gain=256 and hold Math_Ready=1 and AXIS_Out_Ready=1. Pulse start. Required response: 32 beats with Math_X=out_x; User on beat 0 only; Last on beats 7, 15, 23 and 31; done one cycle after beat 31; no gaps.
REQ-035 Use width=1080, Row_Gain=128 and out_x=0. Required response: Math_X=270.
REQ-036 Use width=1080, Row_Gain=512 and out_x=0. Required response: Math_X=0 with BARREL_CLAMP_EN, and 3556 without it.
REQ-037 Hold AXIS_Out_Ready low for 5 cycles mid-row. Required response: Data, Last and User are stable, and Mem_Ready=0. After release, no pixel is lost or duplicated against the reference raster.
REQ-038 Drop Math_Ready for 3 cycles. Required response: Math_X and Math_Y hold, and AXIS_Out_Valid shows a 3-cycle gap after the pipeline latency; the beat sequence is otherwise unchanged.
REQ-039 Assert reset at beat 10. Required response: AXIS_Out_Valid=0 the next cycle, and the state is IDLE. A new start yields a frame from (0,0) with User set.
